evt_packetizer: RTL and testbench
=================================

# evt_packetizer

Address-event packetizer that sits directly downstream of the pixel-group arbitration hierarchy. Each cycle the arbiter grants a pixel, it captures the granted pixel's full row/column address and polarity, optionally tags it with a free-running timestamp, and buffers the resulting packet in a small FIFO. Packets leave on a valid/ready stream toward the readout/serializer. Overflow is handled by dropping new events and counting the drops.

## Interface
- ADDR_W, 3: width of each of the row and column addresses.
- POLARITY, 2: polarity bits per event. Equal to the package value.
- TS_W, 16: timestamp width. Used only when the timestamp feature is compiled in.
- FIFO_DEPTH, 8: packet buffer depth. Must be a power of two, ≥2.
- DROP_W, 8: drop counter width.
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- evt_valid_i  in  1  one-cycle strobe: a pixel grant is present this cycle.
- x_add_i  in  ADDR_W  row address of the granted pixel.
- y_add_i  in  ADDR_W  column address of the granted pixel.
- pol_i  in  POLARITY  polarity of the granted pixel.
- clear_i  in  1  synchronous clear of drop_cnt_o and overflow_o.
- pkt_valid_o  out  1  head packet is available.
- pkt_ready_i  in  1  consumer accepts the head packet.
- pkt_data_o  out  PKT_W  head packet, packed MSB→LSB as {ts, pol, x, y}. PKT_W = 2·ADDR_W+POLARITY(+TS_W).
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- drop_cnt_o  out  DROP_W  number of dropped events. Saturates at all-ones.
- overflow_o  out  1  sticky flag: at least one event has been dropped.

## Operation
- Push: when evt_valid_i=1 and the FIFO is not full, or is full with a pop in the same cycle, the packet {ts_q, pol_i, x_add_i, y_add_i} is written at wr_ptr.
- Pop: when pkt_valid_o & pkt_ready_i, rd_ptr advances.
- FIFO is first-word-fall-through. pkt_data_o shows mem[rd_ptr] whenever count>0. When empty, pkt_data_o is 0.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. The count is tracked separately.
- Full with evt_valid_i=1 and no pop: the event is dropped. drop_cnt_o increments unless it is saturated, and overflow_o is set. FIFO contents are unchanged.
- Simultaneous push and pop: count is unchanged. This holds both when full and when non-empty.
- Empty with push: count goes 0→1. A pop cannot occur in the same cycle because pkt_valid_o is low.
- clear_i zeroes drop_cnt_o and overflow_o.
  - clear_i does not affect the FIFO or the timestamp.
  - If clear_i coincides with a drop, clear wins: the counter reads 0 and the flag is 0.
- pkt_valid_o must not depend combinationally on pkt_ready_i.
- Inputs x_add_i, y_add_i and pol_i are sampled only when evt_valid_i=1.

## Timing
- Reset (reset_i=0, asynchronous):
  - pointers, count and ts_q are 0;
  - pkt_valid_o=0, pkt_data_o=0, fifo_count_o=0, drop_cnt_o=0, overflow_o=0.
- Packet memory is not reset.
- Reset asserted mid-operation discards all buffered packets immediately.
- Latency: an event strobed in cycle N gives pkt_valid_o=1 in cycle N+1 if the FIFO was empty. Minimum 1 cycle.
- Throughput: one push and one pop per cycle, sustained.
- Timestamp:
  - ts_q increments every cycle and wraps from 2^TS_W−1 to 0.
  - The packet carries the ts_q value present in the strobe cycle N.

## Configuration
- EVT_TIMESTAMP_EN defined:
  - ts_q counter exists;
  - the TS_W field is prepended to each packet, so PKT_W = 2·ADDR_W+POLARITY+TS_W.
- EVT_TIMESTAMP_EN undefined:
  - no counter exists;
  - PKT_W = 2·ADDR_W+POLARITY;
  - packet = {pol, x, y}.
- All other behaviour is identical in both builds.

## Structure
- Shared package (lib_arbiter_pkg) holds:
  - POLARITY and EVT_FIFO_DEPTH defaults;
  - an evt_pkt_t packed struct {ts, pol, x, y}, with the ts field under the same macro guard;
  - a PKT_W localparam function.
- Sub-module evt_fifo holds the parameterized FWFT FIFO (width, depth) and exposes full, empty and count.
- The top level adds packing, the timestamp counter and the drop/overflow logic.

## Test plan
- Reset then single event (x=5, y=2, pol=2'b01) at cycle 10 with ready=1:
  - pkt_valid_o=1 at cycle 11;
  - pkt_data_o = {ts=10, 01, 101, 010};
  - then empty.
- ready=0 with 10 consecutive events (FIFO_DEPTH=8): fifo_count_o=8, drop_cnt_o=2, overflow_o=1. Draining then returns the first 8 events in order.
- Full FIFO with push and pop in the same cycle: count stays 8, drop_cnt_o is unchanged, and the new packet emerges last.
- Force 300 drops: drop_cnt_o saturates at 255. clear_i then gives drop_cnt_o=0 and overflow_o=0.
- Timestamp wrap (TS_W=4): an event at ts=15 followed by one at ts=0 yields packets with ts 15 then 0.
- Assert reset_i=0 mid-stream with 4 buffered packets: pkt_valid_o and fifo_count_o go to 0 asynchronously, and no stale packet appears after release.

Source files
------------

// File: rtl/lib_arbiter_pkg.sv
// Shared types and defaults for the event packetizer.
// EVT_TIMESTAMP_EN adds a timestamp field to every packet.
package lib_arbiter_pkg;

    localparam int EVT_POLARITY   = 2;
    localparam int EVT_FIFO_DEPTH = 8;
    localparam int EVT_ADDR_W     = 3;
    localparam int EVT_TS_W       = 16;

`ifdef EVT_TIMESTAMP_EN
    localparam bit EVT_TS_EN = 1'b1;
`else
    localparam bit EVT_TS_EN = 1'b0;
`endif

    typedef struct packed {
`ifdef EVT_TIMESTAMP_EN
        logic [EVT_TS_W-1:0]     ts;
`endif
        logic [EVT_POLARITY-1:0] pol;
        logic [EVT_ADDR_W-1:0]   x;
        logic [EVT_ADDR_W-1:0]   y;
    } evt_pkt_t;

    // The timestamp width only counts when the timestamp field is compiled in.
    function automatic int pkt_width(int addr_w, int pol_w, int ts_w);
        return 2 * addr_w + pol_w + (EVT_TS_EN ? ts_w : 0);
    endfunction

endpackage

// File: rtl/evt_fifo.sv
// First-word-fall-through packet FIFO; head word reads 0 while empty.
// Count is held separately from the wrapping pointers.
module evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_sys,
    input  logic             rst_b,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/evt_packetizer.sv
// Address-event packetizer: captures granted pixel events into a FWFT FIFO,
// counts drops on overflow. EVT_TIMESTAMP_EN prepends a free-running timestamp.
module evt_packetizer
    import lib_arbiter_pkg::*;
#(
    parameter int  ADDR_W     = EVT_ADDR_W,
    parameter int  POLARITY   = EVT_POLARITY,
    parameter int  TS_W       = EVT_TS_W,
    parameter int  FIFO_DEPTH = EVT_FIFO_DEPTH,
    parameter int  DROP_W     = 8,
    localparam int PKT_W      = pkt_width(ADDR_W, POLARITY, TS_W)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          evt_valid_i,
    input  logic [ADDR_W-1:0]             x_add_i,
    input  logic [ADDR_W-1:0]             y_add_i,
    input  logic [POLARITY-1:0]           pol_i,
    input  logic                          clear_i,
    output logic                          pkt_valid_o,
    input  logic                          pkt_ready_i,
    output logic [PKT_W-1:0]              pkt_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic [DROP_W-1:0]             drop_cnt_o,
    output logic                          overflow_o
);

    logic [PKT_W-1:0] pkt_word;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;

`ifdef EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) ts_q <= '0;
        else          ts_q <= ts_q + 1'b1;
    end

    assign pkt_word = {ts_q, pol_i, x_add_i, y_add_i};
`else
    assign pkt_word = {pol_i, x_add_i, y_add_i};
`endif

    // Valid comes from the registered occupancy, never from ready.
    assign pkt_valid_o = !fifo_empty;
    assign pop         = pkt_valid_o && pkt_ready_i;
    assign drop        = evt_valid_i && fifo_full && !pop;

    evt_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys (clk_i),
        .rst_b   (reset_i),
        .push    (evt_valid_i),
        .wr_data (pkt_word),
        .pop     (pop),
        .rd_data (pkt_data_o),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count_o)
    );

    // Clear has priority over a drop landing in the same cycle.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            drop_cnt_o <= '0;
            overflow_o <= 1'b0;
        end else if (drop) begin
            if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
            overflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_evt_packetizer.sv
// Self-checking bench for evt_packetizer: queue-based reference model plus
// directed scenarios and a randomized traffic phase.
module tb_evt_packetizer;

    localparam int AW    = 3;
    localparam int PB    = 2;
    localparam int TSW   = 4;
    localparam int DEPTH = 8;
    localparam int DW    = 8;
`ifdef EVT_TIMESTAMP_EN
    localparam int PKW = 2 * AW + PB + TSW;
`else
    localparam int PKW = 2 * AW + PB;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           evt_valid = 1'b0;
    logic           clear = 1'b0;
    logic           ready = 1'b0;
    logic [AW-1:0]  x = '0;
    logic [AW-1:0]  y = '0;
    logic [PB-1:0]  pol = '0;
    logic           pkt_valid;
    logic [PKW-1:0] pkt_data;
    logic [3:0]     fifo_count;
    logic [DW-1:0]  drop_cnt;
    logic           overflow;

    always #5 clk = ~clk;

    evt_packetizer #(
        .ADDR_W     (AW),
        .POLARITY   (PB),
        .TS_W       (TSW),
        .FIFO_DEPTH (DEPTH),
        .DROP_W     (DW)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst_n),
        .evt_valid_i  (evt_valid),
        .x_add_i      (x),
        .y_add_i      (y),
        .pol_i        (pol),
        .clear_i      (clear),
        .pkt_valid_o  (pkt_valid),
        .pkt_ready_i  (ready),
        .pkt_data_o   (pkt_data),
        .fifo_count_o (fifo_count),
        .drop_cnt_o   (drop_cnt),
        .overflow_o   (overflow)
    );

    int total = 0;
    int bad   = 0;

    logic [PKW-1:0] q[$];
    int m_drops = 0;
    bit m_ovf   = 1'b0;
    int m_ts    = 0;

    function automatic logic [PKW-1:0] mk(int ts, logic [PB-1:0] p, logic [AW-1:0] xa, logic [AW-1:0] ya);
`ifdef EVT_TIMESTAMP_EN
        return {4'(ts), p, xa, ya};
`else
        return {p, xa, ya};
`endif
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // Reference model: what the stream must look like, one cycle at a time.
    always @(posedge clk or negedge rst_n) begin
        bit popx;
        bit was_full;
        if (!rst_n) begin
            q.delete();
            m_ts    = 0;
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            popx     = (q.size() > 0) && ready;
            was_full = (q.size() == DEPTH);
            if (popx) void'(q.pop_front());
            if (evt_valid) begin
                if (!was_full || popx) q.push_back(mk(m_ts, pol, x, y));
                else begin
                    if (m_drops < 255) m_drops++;
                    m_ovf = 1'b1;
                end
            end
            if (clear) begin
                m_drops = 0;
                m_ovf   = 1'b0;
            end
            m_ts = (m_ts + 1) % (1 << TSW);
        end
    end

    always @(negedge clk) begin
        check("valid", 64'(pkt_valid), 64'(q.size() > 0));
        check("count", 64'(fifo_count), 64'(q.size()));
        check("data",  64'(pkt_data), (q.size() > 0) ? 64'(q[0]) : 64'd0);
        check("drops", 64'(drop_cnt), 64'(m_drops));
        check("ovf",   64'(overflow), 64'(m_ovf));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [AW-1:0] xa, logic [AW-1:0] ya, logic [PB-1:0] p);
        evt_valid = v;
        x = xa;
        y = ya;
        pol = p;
    endtask

    task automatic drain();
        ready = 1'b1;
        for (int i = 0; i < 20 && fifo_count != 0; i++) step();
        check("drain_done", 64'(fifo_count), 64'd0);
        ready = 1'b0;
    endtask

    task automatic fill(int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, AW'($urandom), AW'($urandom), PB'($urandom));
            step();
        end
        evt_valid = 1'b0;
    endtask

    logic [PKW-1:0] exp1;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single event in the cycle where ts == 10.
        repeat (10) @(posedge clk);
        #1;
        ready = 1'b1;
        drive(1'b1, 3'd5, 3'd2, 2'b01);
        step();
        evt_valid = 1'b0;
`ifdef EVT_TIMESTAMP_EN
        exp1 = {4'd10, 2'b01, 3'b101, 3'b010};
`else
        exp1 = {2'b01, 3'b101, 3'b010};
`endif
        check("first_valid", 64'(pkt_valid), 64'd1);
        check("first_data", 64'(pkt_data), 64'(exp1));
        step();
        check("first_empty", 64'(pkt_valid), 64'd0);

        // Ten events into a stalled FIFO: two are dropped.
        ready = 1'b0;
        fill(10);
        check("ovf_count", 64'(fifo_count), 64'd8);
        check("ovf_drops", 64'(drop_cnt), 64'd2);
        check("ovf_flag", 64'(overflow), 64'd1);
        drain();

        // Full FIFO with simultaneous push and pop.
        fill(8);
        ready = 1'b1;
        drive(1'b1, 3'd7, 3'd7, 2'b11);
        step();
        evt_valid = 1'b0;
        ready = 1'b0;
        check("pp_count", 64'(fifo_count), 64'd8);
        check("pp_drops", 64'(drop_cnt), 64'd2);
        ready = 1'b1;
        repeat (7) step();
        ready = 1'b0;
        check("pp_last_count", 64'(fifo_count), 64'd1);
        check("pp_last_data", 64'(pkt_data[7:0]), 64'({2'b11, 3'd7, 3'd7}));
        drain();

        // Saturate the drop counter, then clear on top of a drop.
        fill(8 + 300);
        check("sat_drops", 64'(drop_cnt), 64'd255);
        drive(1'b1, 3'd1, 3'd1, 2'b00);
        clear = 1'b1;
        step();
        clear = 1'b0;
        evt_valid = 1'b0;
        check("clr_drops", 64'(drop_cnt), 64'd0);
        check("clr_flag", 64'(overflow), 64'd0);
        drain();

        // Timestamp wrap: events at ts 15 and ts 0.
        for (int i = 0; i < 20 && m_ts != 15; i++) step();
        drive(1'b1, 3'd1, 3'd2, 2'b10);
        step();
        drive(1'b1, 3'd3, 3'd4, 2'b01);
        step();
        evt_valid = 1'b0;
        check("wrap_count", 64'(fifo_count), 64'd2);
`ifdef EVT_TIMESTAMP_EN
        check("wrap_ts15", 64'(pkt_data[PKW-1 -: 4]), 64'd15);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("wrap_ts0", 64'(pkt_data[PKW-1 -: 4]), 64'd0);
`endif
        drain();

        // Asynchronous reset with four packets buffered.
        fill(4);
        check("pre_rst_count", 64'(fifo_count), 64'd4);
        #3 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(pkt_valid), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) step();
        check("post_rst_valid", 64'(pkt_valid), 64'd0);

        // Randomized traffic with shifting consumer bias.
        for (int ph = 0; ph < 10; ph++) begin
            int rbias;
            rbias = $urandom_range(10, 90);
            for (int i = 0; i < 200; i++) begin
                drive(($urandom_range(0, 99) < 60), AW'($urandom), AW'($urandom), PB'($urandom));
                ready = ($urandom_range(0, 99) < rbias);
                clear = ($urandom_range(0, 99) < 2);
                step();
            end
        end
        evt_valid = 1'b0;
        clear = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
